inst_issue_seq: RTL
===================

# inst_issue_seq

Instruction issue sequencer that replaces bench-driven instruction streams in front of the 32-bit core. It loads a small program into an internal buffer, then issues it one instruction per accepted cycle on the core's 32-bit `inst` input. Before issue, it checks every word against the core's R-type instruction format. Sits between the program loader (write port) and `procsn32`.

## Interface
- `DEPTH`, 16: program buffer entries; must be a power of two.
- `AW`, 4: address width, log2(DEPTH).
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  program write strobe.
- `wr_addr`  in  AW  program write address.
- `wr_data`  in  32  instruction word to store.
- `start`  in  1  one-cycle run request.
- `prog_len`  in  AW+1  number of words to issue; sampled when `start` is accepted.
- `stall`  in  1  core is not consuming; hold the current issue.
- `inst`  out  32  instruction presented to the core.
- `inst_valid`  out  1  `inst` holds a real instruction.
- `pc`  out  AW  buffer index of the next word to issue.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  program fully issued; sticky until the next `start`.
- `err`  out  1  illegal word found; sticky until the next `start`.

## Operation
- Word format, from MSB to LSB: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7], opcode[6:0].
- Legal words have funct7 = 0 and one of these opcode/funct3 pairs:
  - 0x01 (arith): funct3 0 ADD, 1 SUB.
  - 0x03 (shift): funct3 0 SLL, 1 SRL, 2 SRA.
  - 0x07 (compare): funct3 0 SLT, 1 SLTU.
  - 0x0f (logic): funct3 0 XOR, 1 OR, 2 AND.
  - Everything else is illegal.
- Writes land only when `busy` = 0; writes during RUN or DRAIN are dropped. Buffer contents are not cleared by reset.
- FSM states: IDLE, RUN, DRAIN, DONE, ERR.
  - IDLE, DONE or ERR, with `start` = 1: clear `done`/`err`, set `pc` = 0, latch len = min(`prog_len`, DEPTH). Go to RUN if len > 0. If len = 0, go to DONE and set `done` on that edge.
  - RUN with `stall` = 1: hold `inst`, `inst_valid`, `pc` and state.
  - RUN with `stall` = 0 and mem[pc] legal: `inst` <= mem[pc], `inst_valid` <= 1, `pc` <= pc+1. If pc = len-1, go to DRAIN.
  - RUN with `stall` = 0 and mem[pc] illegal: `inst` <= 0, `inst_valid` <= 0, `err` <= 1, go to ERR. `pc` keeps the index of the offending word.
  - DRAIN with `stall` = 1: hold.
  - DRAIN with `stall` = 0: `inst` <= 0, `inst_valid` <= 0, `done` <= 1, go to DONE.
- `start` in RUN or DRAIN is ignored.
- `pc` is AW bits wide. When len = DEPTH, `pc` wraps to 0 after the last issue; this is harmless because the FSM is in DRAIN by then.

## Timing
- Reset values (applied asynchronously on `reset_n` low): state IDLE, `inst` = 0, `inst_valid` = 0, `pc` = 0, `busy` = 0, `done` = 0, `err` = 0.
- `start` is sampled at edge k. The first `inst_valid` = 1 appears after edge k+1, i.e. two-edge latency from `start` to first issue.
- Steady state: one instruction per unstalled cycle. `stall` is sampled on the same edge that would advance the issue.
- An N-word program with no stalls has `inst_valid` high for N cycles. `done` rises on edge k+N+1.
- `busy` is registered together with the state.
- Write-then-start:
  - A write at edge j is readable by an issue at edge j+1 or later.
  - `wr_en` and `start` on the same edge from IDLE: the write still lands, because the write check uses the pre-edge `busy` value.
- Reset asserted mid-run: all outputs go to their reset values immediately. The program buffer is retained.

## Test plan
- Load [0]=0x00208501 (ADD r10,r1,r2) and [1]=0x00209581 (SUB r11,r1,r2), start with `prog_len`=2 -> `inst` shows 0x00208501 then 0x00209581 on consecutive cycles, `pc` goes 1 then 2, and `done` = 1 on the third edge after start with `inst` = 0.
- Same program, `stall` high for 3 cycles while 0x00208501 is valid -> `inst` and `pc` hold for 3 cycles, then SUB issues; `done` is delayed by exactly 3 cycles.
- Program [0]=0x0020A98F (AND), [1]=0x00208505 (opcode 0x05), `prog_len`=2 -> AND issues, then `err` = 1, `inst_valid` = 0, `pc` = 1, state ERR; a new `start` clears `err`.
- `prog_len` = 0 -> `done` = 1 one edge after start, `inst_valid` stays 0. `prog_len` = 20 with DEPTH=16 -> exactly 16 issues.
- Write to [0] during RUN and pulse `start` in RUN -> both are ignored; a rerun issues the original word.
- `reset_n` low midway through a 4-word run -> all outputs 0 asynchronously; after release, start with `prog_len`=4 -> all 4 original words issue.

Source files
------------

// File: rtl/inst_issue_seq.sv
// Instruction issue sequencer. It loads a program into a small buffer, checks
// each word against the core's R-type format, and issues one word per
// unstalled cycle to the core.
module inst_issue_seq #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    input  logic          stall,
    output logic [31:0]   inst,
    output logic          inst_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [31:0]   inst_q, inst_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   cur_word;
    logic [AW:0]   start_len;

    // Legal words have funct7 = 0 and one of the listed opcode/funct3 pairs.
    function automatic logic is_legal(input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        if (w[31:25] == 7'h00) begin
            case (w[6:0])
                7'h01:   ok = (w[14:12] <= 3'd1);
                7'h03:   ok = (w[14:12] <= 3'd2);
                7'h07:   ok = (w[14:12] <= 3'd1);
                7'h0f:   ok = (w[14:12] <= 3'd2);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    assign cur_word  = mem_q[pc_q];
    assign start_len = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

    // Program buffer: no reset, so contents survive a reset; writes are
    // dropped while a program is being issued (pre-edge busy).
    always_ff @(posedge clock) begin
        if (wr_en && !busy_q) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Next-state and output logic for the issue FSM.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        len_d   = len_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    pc_d   = '0;
                    len_d  = start_len;
                    if (start_len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (is_legal(cur_word)) begin
                        inst_d  = cur_word;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 1'b1;
                        if ({1'b0, pc_q} == len_q - 1'b1) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        // pc stays on the offending word for debug
                        inst_d  = '0;
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_DRAIN: begin
                if (!stall) begin
                    inst_d  = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            inst_q  <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign pc         = pc_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
